// File: rtl/maclaurin_pkg.sv
// Shared definitions for the Maclaurin-series function controllers (sin/cos/exp).
// Holds the sequencer state type, fixed-point widths and the multiply-shift helper.
package maclaurin_pkg;

    localparam int DATA_W     = 16;
    localparam int LUT_ADDR_W = 3;
    localparam int LUT_DEPTH  = 8;
    localparam int FRAC_BITS  = 16;
    localparam int ACC_W      = DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQUARE = 3'd1,
        TERM   = 3'd2,
        POWER  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Unsigned Q0.16 x Q0.16 -> Q0.16, truncating the low fraction bits.
    function automatic logic [DATA_W-1:0] mul_shift(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return prod[FRAC_BITS +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] clamp_u(input logic signed [ACC_W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > $signed({2'b00, {DATA_W{1'b1}}}))
            return {DATA_W{1'b1}};
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sin_series_ctrl_if.sv
// Operand handshake shared by the series controllers: start/x_in in, busy/done/result out.
interface sin_series_ctrl_if #(
    parameter int DATA_W = maclaurin_pkg::DATA_W
);
    logic              start;
    logic [DATA_W-1:0] x_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (output start, output x_in, input busy, input done, input result);
    modport slave  (input start, input x_in, output busy, output done, output result);
endinterface

// File: rtl/sin_series_ctrl.sv
// Sequencer evaluating sin(x) = x - x^3/3! + x^5/5! - ... over an external coefficient LUT.
// One multiply per TERM (coefficient * power) and one per POWER (power * x^2).
//
// state  | meaning
// IDLE   | waiting for start; captures x_in on acceptance
// SQUARE | computes x^2, seeds power with x, clears accumulator and term index
// TERM   | addresses LUT with k, adds/subtracts power*coef into accumulator
// POWER  | advances power by x^2, increments k
// DONE   | one-cycle done pulse with the clamped result
module sin_series_ctrl #(
    parameter int NUM_TERMS = 4,
    parameter int DATA_W    = maclaurin_pkg::DATA_W
) (
    input  logic                               clk,
    input  logic                               rst,
    sin_series_ctrl_if.slave                   op,
    output logic [maclaurin_pkg::LUT_ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0]                  lut_data
);
    import maclaurin_pkg::*;

    // Term count is clamped to the LUT depth so k never wraps.
    localparam int NT = (NUM_TERMS > LUT_DEPTH) ? LUT_DEPTH :
                        ((NUM_TERMS < 1) ? 1 : NUM_TERMS);
    localparam logic [LUT_ADDR_W-1:0] K_LAST = LUT_ADDR_W'(NT - 1);

    state_t                  state, state_nxt;
    logic [DATA_W-1:0]       x_q, x_nxt;
    logic [DATA_W-1:0]       x2_q, x2_nxt;
    logic [DATA_W-1:0]       p_q, p_nxt;
    logic [DATA_W-1:0]       result_q, result_nxt;
    logic signed [ACC_W-1:0] acc_q, acc_nxt;
    logic [LUT_ADDR_W-1:0]   k_q, k_nxt;

    logic                    busy_c;
    logic                    done_c;
    logic [LUT_ADDR_W-1:0]   addr_c;
    logic [DATA_W-1:0]       term;
    logic signed [ACC_W-1:0] term_s;

    assign term   = mul_shift(p_q, lut_data);
    assign term_s = $signed({2'b00, term});

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            x_q      <= '0;
            x2_q     <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else begin
            state    <= state_nxt;
            x_q      <= x_nxt;
            x2_q     <= x2_nxt;
            p_q      <= p_nxt;
            acc_q    <= acc_nxt;
            k_q      <= k_nxt;
            result_q <= result_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_q;
        x2_nxt     = x2_q;
        p_nxt      = p_q;
        acc_nxt    = acc_q;
        k_nxt      = k_q;
        result_nxt = result_q;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        addr_c     = '0;

        case (state)
            IDLE: begin
                if (op.start) begin
                    x_nxt     = op.x_in;
                    state_nxt = SQUARE;
                end
            end
            SQUARE: begin
                busy_c    = 1'b1;
                x2_nxt    = mul_shift(x_q, x_q);
                p_nxt     = x_q;
                acc_nxt   = '0;
                k_nxt     = '0;
                state_nxt = TERM;
            end
            TERM: begin
                busy_c  = 1'b1;
                addr_c  = k_q;
                acc_nxt = k_q[0] ? (acc_q - term_s) : (acc_q + term_s);
                // Result is registered on the way into DONE so it is valid with done.
                if (k_q == K_LAST) begin
                    result_nxt = clamp_u(acc_nxt);
                    state_nxt  = DONE;
                end else begin
                    state_nxt  = POWER;
                end
            end
            POWER: begin
                busy_c    = 1'b1;
                p_nxt     = mul_shift(p_q, x2_q);
                k_nxt     = k_q + 1'b1;
                state_nxt = TERM;
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign op.busy   = busy_c;
    assign op.done   = done_c;
    assign op.result = result_q;
    assign lut_addr  = addr_c;

endmodule

// File: tb/tb_sin_series_ctrl.sv
// Bench for sin_series_ctrl: three instances (4, 1 and 9->8 terms) against a series reference model.
module tb_sin_series_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic        start_v [3];
    logic [15:0] x_drv;
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [15:0] res_v   [3];
    logic [2:0]  addr_v  [3];
    logic [15:0] data_v  [3];

    function automatic logic [15:0] lut_coef(input logic [2:0] k);
        case (k)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'h2AAA;
            3'd2:    return 16'h0222;
            3'd3:    return 16'h000D;
            default: return 16'h0000;
        endcase
    endfunction

    sin_series_ctrl_if if4 ();
    sin_series_ctrl_if if1 ();
    sin_series_ctrl_if if9 ();

    assign if4.start = start_v[0];
    assign if1.start = start_v[1];
    assign if9.start = start_v[2];
    assign if4.x_in  = x_drv;
    assign if1.x_in  = x_drv;
    assign if9.x_in  = x_drv;
    assign busy_v[0] = if4.busy;   assign done_v[0] = if4.done;   assign res_v[0] = if4.result;
    assign busy_v[1] = if1.busy;   assign done_v[1] = if1.done;   assign res_v[1] = if1.result;
    assign busy_v[2] = if9.busy;   assign done_v[2] = if9.done;   assign res_v[2] = if9.result;
    assign data_v[0] = lut_coef(addr_v[0]);
    assign data_v[1] = lut_coef(addr_v[1]);
    assign data_v[2] = lut_coef(addr_v[2]);

    sin_series_ctrl #(.NUM_TERMS(4), .DATA_W(16)) dut4 (
        .clk(clk), .rst(rst), .op(if4.slave), .lut_addr(addr_v[0]), .lut_data(data_v[0]));
    sin_series_ctrl #(.NUM_TERMS(1), .DATA_W(16)) dut1 (
        .clk(clk), .rst(rst), .op(if1.slave), .lut_addr(addr_v[1]), .lut_data(data_v[1]));
    sin_series_ctrl #(.NUM_TERMS(9), .DATA_W(16)) dut9 (
        .clk(clk), .rst(rst), .op(if9.slave), .lut_addr(addr_v[2]), .lut_data(data_v[2]));

    function automatic int nt_eff(input int which);
        case (which)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Series evaluated directly from its definition with truncating Q0.16 products.
    function automatic logic [15:0] ref_sin(input logic [15:0] x, input int nt);
        longint xx, x2, p, acc, t;
        xx  = longint'(x);
        x2  = (xx * xx) >> 16;
        p   = xx;
        acc = 0;
        for (int k = 0; k < nt; k++) begin
            t   = (p * longint'(lut_coef(3'(k)))) >> 16;
            acc = (k % 2 == 0) ? acc + t : acc - t;
            p   = (p * x2) >> 16;
        end
        if (acc < 0)     return 16'h0000;
        if (acc > 65535) return 16'hFFFF;
        return 16'(acc);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0 with start high.
    task automatic run_txn(input int which, input logic [15:0] x, input bit repulse,
                           output int done_cyc, output int ndone, output logic [15:0] res,
                           output bit busy_ok, output bit lut_ok);
        int nt;
        int exp_done;
        logic [2:0] exp_addr;
        nt       = nt_eff(which);
        exp_done = 2 * nt + 1;
        done_cyc = -1;
        ndone    = 0;
        res      = 16'h0;
        busy_ok  = 1'b1;
        lut_ok   = 1'b1;
        x_drv          = x;
        start_v[which] = 1'b1;
        for (int c = 1; c <= exp_done + 4; c++) begin
            @(negedge clk);
            if (done_v[which]) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res      = res_v[which];
                end
            end
            if (busy_v[which] !== (c <= exp_done)) busy_ok = 1'b0;
            exp_addr = (c >= 2 && c <= 2 * nt && c % 2 == 0) ? 3'((c - 2) / 2) : 3'd0;
            if (addr_v[which] !== exp_addr) lut_ok = 1'b0;
            if (repulse && (c == 3 || c == 5)) begin
                start_v[which] = 1'b1;
                x_drv          = ~x;
            end else begin
                start_v[which] = 1'b0;
                x_drv          = 16'($urandom);
            end
        end
    endtask

    task automatic full_check(input string tag, input int which, input logic [15:0] x,
                              input bit repulse);
        int dc, nd;
        logic [15:0] r, e;
        bit bok, lok;
        e = ref_sin(x, nt_eff(which));
        run_txn(which, x, repulse, dc, nd, r, bok, lok);
        chk({tag, "_done_cycle"}, dc, 2 * nt_eff(which) + 1);
        chk({tag, "_done_count"}, nd, 1);
        chk({tag, "_result"}, r, e);
        chk({tag, "_result_hold"}, res_v[which], e);
        chk({tag, "_busy_window"}, bok, 1);
        chk({tag, "_lut_addr_seq"}, lok, 1);
    endtask

    initial begin
        int dc, nd, diff;
        logic [15:0] r;
        bit bok, lok;
        logic [15:0] rx;
        bit saw_done;

        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        x_drv = 16'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy",   busy_v[i], 0);
            chk("reset_done",   done_v[i], 0);
            chk("reset_result", res_v[i],  0);
            chk("reset_addr",   addr_v[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        full_check("zero_nt4", 0, 16'h0000, 1'b0);
        chk("zero_nt4_value", res_v[0], 16'h0000);

        run_txn(0, 16'h8000, 1'b0, dc, nd, r, bok, lok);
        diff = (int'(r) > 32'h7ABB) ? int'(r) - 32'h7ABB : 32'h7ABB - int'(r);
        chk("half_rad_tol", (diff <= 4), 1);
        chk("half_rad_lut_seq", lok, 1);

        run_txn(0, 16'hFFFF, 1'b0, dc, nd, r, bok, lok);
        diff = (int'(r) > 32'hD76B) ? int'(r) - 32'hD76B : 32'hD76B - int'(r);
        chk("one_rad_tol", (diff <= 4), 1);
        chk("one_rad_no_clamp", (r != 16'hFFFF), 1);

        full_check("nt1_half", 1, 16'h8000, 1'b0);
        chk("nt1_half_value", res_v[1], 16'h7FFF);

        full_check("nt9_clamped", 2, 16'hC000, 1'b0);

        full_check("repulse_ignored", 0, 16'h6000, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rx = 16'($urandom);
            full_check("rand_nt4", 0, rx, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            rx = 16'($urandom);
            full_check("rand_nt1", 1, rx, 1'b0);
            rx = 16'($urandom);
            full_check("rand_nt8", 2, rx, 1'b0);
        end

        // Reset in cycle 5 of a running calculation.
        x_drv      = 16'h8000;
        start_v[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        chk("pre_rst_busy", busy_v[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy",   busy_v[0], 0);
        chk("rst_mid_result", res_v[0],  0);
        chk("rst_mid_done",   done_v[0], 0);
        chk("rst_mid_addr",   addr_v[0], 0);
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", saw_done, 0);
        full_check("after_rst", 0, 16'h8000, 1'b0);

        // Reset and start together: reset wins.
        x_drv      = 16'h4000;
        start_v[0] = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        rst        = 1'b0;
        chk("rst_start_busy", busy_v[0], 0);
        @(negedge clk);
        chk("rst_start_stay_idle", busy_v[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
